// File: rtl/mem_responder.sv
// Single-port 16-bit memory responder with a request/acknowledge handshake.
// Define MEM_WAIT_STATE_EN to insert WAIT_CYCLES wait states before each response.
module mem_responder #(
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [15:0] MemReadAddr,
    input  logic [15:0] MemInputData,
    output logic [15:0] MemOut,
    output logic        MemAck,
    output logic        MemBusy,
    output logic        MemErr
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 1 << ADDR_BITS;

    // Elaboration-time parameter range checks
    if (ADDR_BITS == 0 || ADDR_BITS > ADDR_W) begin : g_bad_addr_bits
        $error("mem_responder: ADDR_BITS must be in 1..16");
    end
    if (WAIT_CYCLES == 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("mem_responder: WAIT_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef MEM_WAIT_STATE_EN
        WAIT = 2'd1,
`endif
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] out_q,   out_d;
    logic              ack_q,   ack_d;
    logic              busy_q,  busy_d;
    logic              err_q,   err_d;

    logic              oor_c;
    logic              mem_we_c;
    logic [DATA_W-1:0] rd_data_c;

    logic [DATA_W-1:0] mem [DEPTH];

`ifdef MEM_WAIT_STATE_EN
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Any address bit above the implemented range marks the access as out of range
    assign oor_c     = (addr_q >> ADDR_BITS) != '0;
    assign rd_data_c = mem[addr_q[ADDR_BITS-1:0]];

    assign MemOut  = out_q;
    assign MemAck  = ack_q;
    assign MemBusy = busy_q;
    assign MemErr  = err_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        out_d    = out_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        busy_d   = busy_q;
        mem_we_c = 1'b0;
`ifdef MEM_WAIT_STATE_EN
        cnt_d    = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (MemReq) begin
                    write_d = MemWrite;
                    addr_d  = MemReadAddr;
                    wdata_d = MemInputData;
                    busy_d  = 1'b1;
`ifdef MEM_WAIT_STATE_EN
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
`else
                    state_d = RESP;
`endif
                end
            end
`ifdef MEM_WAIT_STATE_EN
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            RESP: begin
                ack_d   = 1'b1;
                err_d   = oor_c;
                busy_d  = 1'b0;
                state_d = IDLE;
                // A write leaves MemOut untouched; reset aborts the pending write
                if (write_q) begin
                    mem_we_c = !oor_c && !Reset;
                end else begin
                    out_d = oor_c ? '0 : rd_data_c;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            out_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MEM_WAIT_STATE_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            out_q   <= out_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
`ifdef MEM_WAIT_STATE_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge CLK) begin
        if (mem_we_c) begin
            mem[addr_q[ADDR_BITS-1:0]] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: randomized accesses against a word-array model,
// with a decoupled monitor checking data, error flag and acknowledge timing.
module tb_mem_responder;
    localparam int AB = 8;
    localparam int WC = 2;
`ifdef MEM_WAIT_STATE_EN
    localparam int LAT = WC + 1;
`else
    localparam int LAT = 1;
`endif

    logic        CLK;
    logic        Reset;
    logic        MemReq;
    logic        MemWrite;
    logic [15:0] MemReadAddr;
    logic [15:0] MemInputData;
    logic [15:0] MemOut;
    logic        MemAck;
    logic        MemBusy;
    logic        MemErr;

    mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(WC)) dut (
        .CLK(CLK), .Reset(Reset), .MemReq(MemReq), .MemWrite(MemWrite),
        .MemReadAddr(MemReadAddr), .MemInputData(MemInputData),
        .MemOut(MemOut), .MemAck(MemAck), .MemBusy(MemBusy), .MemErr(MemErr)
    );

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mdl [2**AB];
    logic [15:0] last_out;
    int          cyc = 0;
    int          ack_count = 0;
    int          checks = 0;
    int          failures = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: unexpected condition at cycle %0d", name, cyc);
    endtask

    // Monitor: pop the expected response whenever an acknowledge appears
    always @(negedge CLK) begin
        if (!Reset) begin
            if (MemAck) begin
                ack_count++;
                if (q.size() == 0) begin
                    fail("unexpected_ack");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("ack_cycle", cyc, e.cyc);
                    check("mem_out", MemOut, e.data);
                    check("mem_err", MemErr, e.err);
                end
            end else begin
                if (MemErr) fail("err_without_ack");
                if (q.size() > 0 && cyc >= q[0].cyc) begin
                    fail("missing_ack");
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        MemReq = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Issue one access into an idle responder; scrambles inputs while it is busy
    task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                          input bit hold);
        exp_t        e;
        bit          oor;
        logic [AB-1:0] idx;
        MemReq       = 1'b1;
        MemWrite     = wr;
        MemReadAddr  = addr;
        MemInputData = data;
        @(posedge CLK);
        #1;
        check("busy_after_accept", MemBusy, 1'b1);
        oor = (addr >> AB) != 0;
        idx = addr[AB-1:0];
        if (wr) begin
            if (!oor) mdl[idx] = data;
        end else begin
            last_out = oor ? 16'h0000 : mdl[idx];
        end
        e.data = last_out;
        e.err  = oor;
        e.cyc  = cyc + LAT;
        q.push_back(e);
        MemReq       = hold;
        MemWrite     = ~wr;
        MemReadAddr  = 16'($urandom);
        MemInputData = 16'($urandom);
        repeat (LAT) @(posedge CLK);
        #1;
        check("busy_in_ack_cycle", MemBusy, 1'b0);
    endtask

    task automatic do_reset();
        Reset  = 1'b1;
        MemReq = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        Reset  = 1'b0;
        MemReq = 1'b0;
        q.delete();
        last_out = 16'h0000;
        check("rst_mem_out", MemOut, 16'h0000);
        check("rst_mem_ack", MemAck, 1'b0);
        check("rst_mem_busy", MemBusy, 1'b0);
        check("rst_mem_err", MemErr, 1'b0);
    endtask

    initial begin
        int a0;
        Reset        = 1'b1;
        MemReq       = 1'b0;
        MemWrite     = 1'b0;
        MemReadAddr  = 16'h0000;
        MemInputData = 16'h0000;
        last_out     = 16'h0000;
        do_reset();

        // Preload the low words so every later in-range read is defined
        for (int i = 0; i < 32; i++) access(1'b1, 16'(i), 16'($urandom), 1'b0);
        access(1'b1, 16'h0005, 16'hBEEF, 1'b0);

        // Write/read round trip at 0x0010
        access(1'b1, 16'h0010, 16'h00A5, 1'b0);
        access(1'b0, 16'h0010, 16'h0000, 1'b0);

        // Out-of-range write must not alias onto word 0
        access(1'b1, 16'h0000, 16'h5555, 1'b0);
        access(1'b1, 16'h0100, 16'h7777, 1'b1);
        access(1'b0, 16'h0100, 16'hFFFF, 1'b0);
        access(1'b0, 16'h0000, 16'h0000, 1'b0);
        idle(1);

        // MemReq held high throughout: one ack per LAT+1 cycles, nothing captured while busy
        a0 = ack_count;
        for (int k = 0; k < 5; k++) access(1'b0, (k % 2 == 0) ? 16'h0003 : 16'h0004, 16'h0, 1'b1);
        idle(1);
        check("burst_ack_count", ack_count - a0, 5);

        // Reset while the write is pending aborts it
        MemReq       = 1'b1;
        MemWrite     = 1'b1;
        MemReadAddr  = 16'h0005;
        MemInputData = 16'h1234;
        @(posedge CLK);
        #1;
        check("abort_busy_after_accept", MemBusy, 1'b1);
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        Reset  = 1'b0;
        MemReq = 1'b0;
        last_out = 16'h0000;
        check("abort_busy_cleared", MemBusy, 1'b0);
        check("abort_mem_out", MemOut, 16'h0000);
        a0 = ack_count;
        idle(LAT + 2);
        check("abort_no_ack", ack_count - a0, 0);
        access(1'b0, 16'h0005, 16'h0000, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            logic [15:0] addr;
            if ($urandom_range(0, 4) == 0)
                addr = 16'($urandom_range(1, 255) << 8) | 16'($urandom_range(0, 255));
            else
                addr = 16'($urandom_range(0, 31));
            access(1'($urandom_range(0, 1)), addr, 16'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        idle(LAT + 3);
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
